shift_exec_stage: RTL
=====================

Name: shift_exec_stage

Overview:
- Two-stage pipelined shift execution unit for the MIPS execute path.
- Accepts decoded R-type shift operations: SLL, SRL, SRA, SLLV, SRLV, SRAV.
- Resolves the shift amount and computes the result with a 5-level barrel network (16/8/4/2/1, logical and arithmetic fill).
- Delivers the registered result and destination register to writeback over a valid/ready handshake, with full backpressure.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported, and the amount field is fixed at 5 bits.
- DEST_W, 5, destination register index width.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage 1 can accept this cycle.
- in_funct  input  6  MIPS funct field.
- in_shamt  input  5  immediate shift amount (SLL/SRL/SRA).
- in_rs_data  input  32  rs value; bits [4:0] give the amount for the V-forms, upper bits ignored.
- in_rt_data  input  32  operand to shift.
- in_rd  input  5  destination register.
- out_valid  output  1  result held in stage 2.
- out_ready  input  1  downstream accepts.
- out_result  output  32  shifted value.
- out_rd  output  5  destination register.
- out_illegal  output  1  funct was not a shift op.
- busy  output  1  either stage holds a valid op.

Behaviour:
- Reset (reset_n low, asynchronous): both stage valid bits are 0.
  - out_valid=0, out_result=0, out_rd=0, out_illegal=0, busy=0.
  - in_ready reads 1 as soon as reset_n is high.
  - Reset asserted mid-operation discards all in-flight ops; nothing is emitted afterwards.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - out_result, out_rd and out_illegal stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- Stage 1 (decode register): on input transfer, latches:
  - op class: left-logical, right-logical or right-arithmetic.
  - resolved amount: in_shamt for funct 000000/000010/000011; in_rs_data[4:0] for 000100/000110/000111.
  - in_rt_data, in_rd, and the illegal flag (set for any other funct).
- Stage 2 (result register): loads the barrel-network result computed from stage 1.
  - SLL/SLLV: zero fill from the LSB.
  - SRL/SRLV: zero fill from the MSB.
  - SRA/SRAV: fill with the operand's bit 31 at every level.
  - Illegal op: result 0, out_illegal=1, rd passed through.
- Advance rules:
  - Stage 2 loads when it is empty or its output transfers this cycle.
  - Stage 1 loads when it is empty or it advances into stage 2 this cycle.
  - in_ready = !s1_valid | s2_can_load.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Timing:
  - Latency: an op accepted at edge N is visible on out_valid after edge N+1.
  - Throughput: 1 op/cycle when out_ready is held high.
- Full condition: with both stages valid and out_ready=0, in_ready=0 and no data is lost or overwritten.
- Simultaneous events: on the same edge, an output transfer, a stage 1→2 advance and a new input transfer all occur; ordering is preserved.
- Amount 0: result equals the operand for every class.
- Amount 31, SRA: result is 0xFFFFFFFF or 0x00000000 according to bit 31.
- busy = s1_valid | s2_valid.

Test Plan:
- SRA in_rt_data=0x80000000, in_shamt=4, out_ready=1 -> out_result=0xF8000000 two cycles after acceptance; out_rd echoes in_rd; out_illegal=0.
- SRAV in_rs_data=0x00000023, in_rt_data=0xFFFFFFF0 -> amount 3, out_result=0xFFFFFFFE.
- SRLV with the same inputs -> out_result=0x1FFFFFFE.
- SLL in_rt_data=0x00000001, in_shamt=31 -> out_result=0x80000000.
- Back-to-back ops:
  - Issue three ops on consecutive cycles with out_ready=0.
  - Required: in_ready falls after two are accepted and the third is held upstream.
  - Then raise out_ready: results appear in order, one per cycle, with values unchanged during the stall.
- in_funct=0x20 (ADD) -> out_illegal=1, out_result=0x00000000, out_rd passed through; the following legal op is unaffected.
- Reset mid-operation:
  - Pulse reset_n low asynchronously (between edges) while both stages are valid.
  - Required: out_valid and busy fall immediately without waiting for a clock edge; after release no stale result is emitted and in_ready=1.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Two-stage MIPS shift execution unit: stage 1 registers the decoded op,
// stage 2 registers the barrel-shifted result for writeback (valid/ready).
module shift_exec_stage #(
  parameter int WIDTH  = 32,
  parameter int DEST_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [WIDTH-1:0]  in_rs_data,
  input  logic [WIDTH-1:0]  in_rt_data,
  input  logic [DEST_W-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [DEST_W-1:0] out_rd,
  output logic              out_illegal,
  output logic              busy
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holding valid keeps its payload stable until that edge.

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  localparam logic [1:0] CLS_LEFT = 2'd0;
  localparam logic [1:0] CLS_RL   = 2'd1;
  localparam logic [1:0] CLS_RA   = 2'd2;

  logic              s1_valid_q, s1_valid_d;
  logic [1:0]        s1_class_q, s1_class_d;
  logic [4:0]        s1_amt_q, s1_amt_d;
  logic [WIDTH-1:0]  s1_data_q, s1_data_d;
  logic [DEST_W-1:0] s1_rd_q, s1_rd_d;
  logic              s1_illegal_q, s1_illegal_d;

  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  s2_result_q, s2_result_d;
  logic [DEST_W-1:0] s2_rd_q, s2_rd_d;
  logic              s2_illegal_q, s2_illegal_d;

  logic              s2_can_load, s1_advance, in_xfer;
  logic [1:0]        dec_class;
  logic [4:0]        dec_amt;
  logic              dec_illegal;
  logic              fill, shift_left;
  logic [WIDTH-1:0]  sh16, sh8, sh4, sh2, sh1;
  logic              unused_rs_hi;

  // Only the low five bits of rs carry the variable amount.
  assign unused_rs_hi = ^in_rs_data[WIDTH-1:5];

  assign s2_can_load = !s2_valid_q || out_ready;
  assign s1_advance  = s1_valid_q && s2_can_load;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign in_xfer     = in_valid && in_ready;

  always_comb begin
    dec_class   = CLS_LEFT;
    dec_amt     = in_shamt;
    dec_illegal = 1'b0;
    case (in_funct)
      F_SLL:  dec_class = CLS_LEFT;
      F_SRL:  dec_class = CLS_RL;
      F_SRA:  dec_class = CLS_RA;
      F_SLLV: begin dec_class = CLS_LEFT; dec_amt = in_rs_data[4:0]; end
      F_SRLV: begin dec_class = CLS_RL;   dec_amt = in_rs_data[4:0]; end
      F_SRAV: begin dec_class = CLS_RA;   dec_amt = in_rs_data[4:0]; end
      default: begin dec_amt = 5'd0; dec_illegal = 1'b1; end
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_class_d   = s1_class_q;
    s1_amt_d     = s1_amt_q;
    s1_data_d    = s1_data_q;
    s1_rd_d      = s1_rd_q;
    s1_illegal_d = s1_illegal_q;
    if (in_xfer) begin
      s1_valid_d   = 1'b1;
      s1_class_d   = dec_class;
      s1_amt_d     = dec_amt;
      s1_data_d    = in_rt_data;
      s1_rd_d      = in_rd;
      s1_illegal_d = dec_illegal;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Arithmetic fill is the operand's sign bit; it stays in bit 31 through
  // every right-shift level, so one fill bit serves all five levels.
  assign fill       = (s1_class_q == CLS_RA) && s1_data_q[WIDTH-1];
  assign shift_left = (s1_class_q == CLS_LEFT);

  always_comb begin
    sh16 = s1_data_q;
    if (s1_amt_q[4])
      sh16 = shift_left ? {s1_data_q[WIDTH-17:0], 16'h0} : {{16{fill}}, s1_data_q[WIDTH-1:16]};
    sh8 = sh16;
    if (s1_amt_q[3])
      sh8 = shift_left ? {sh16[WIDTH-9:0], 8'h0} : {{8{fill}}, sh16[WIDTH-1:8]};
    sh4 = sh8;
    if (s1_amt_q[2])
      sh4 = shift_left ? {sh8[WIDTH-5:0], 4'h0} : {{4{fill}}, sh8[WIDTH-1:4]};
    sh2 = sh4;
    if (s1_amt_q[1])
      sh2 = shift_left ? {sh4[WIDTH-3:0], 2'b0} : {{2{fill}}, sh4[WIDTH-1:2]};
    sh1 = sh2;
    if (s1_amt_q[0])
      sh1 = shift_left ? {sh2[WIDTH-2:0], 1'b0} : {fill, sh2[WIDTH-1:1]};
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_rd_d      = s2_rd_q;
    s2_illegal_d = s2_illegal_q;
    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d  = s1_illegal_q ? '0 : sh1;
        s2_rd_d      = s1_rd_q;
        s2_illegal_d = s1_illegal_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_class_q   <= CLS_LEFT;
      s1_amt_q     <= 5'd0;
      s1_data_q    <= '0;
      s1_rd_q      <= '0;
      s1_illegal_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_class_q   <= s1_class_d;
      s1_amt_q     <= s1_amt_d;
      s1_data_q    <= s1_data_d;
      s1_rd_q      <= s1_rd_d;
      s1_illegal_q <= s1_illegal_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_rd_q      <= s2_rd_d;
      s2_illegal_q <= s2_illegal_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_rd      = s2_rd_q;
  assign out_illegal = s2_illegal_q;
  assign busy        = s1_valid_q || s2_valid_q;

endmodule
